// File: rtl/ttt_pkg.sv
// ============================================================================
// Module   : ttt_pkg
// Purpose  : Shared types and constants for the tic-tac-toe game controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN_A = 3'd3,
        WIN_B = 3'd4,
        DRAW  = 3'd5
    } state_t;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

    // Rows 0-2, columns 3-5, diagonal 6, anti-diagonal 7.
    localparam logic [8:0] LINES [0:7] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_line_check.sv
// ============================================================================
// Module   : ttt_line_check
// Purpose  : Flags every completed three-in-a-row line on a single board.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] board_i,
    output logic [7:0] line_hit_o
);

    for (genvar i = 0; i < 8; i++) begin : g_line
        assign line_hit_o[i] = ((board_i & LINES[i]) == LINES[i]);
    end

endmodule

`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
// ============================================================================
// Module   : ttt_game_ctrl
// Purpose  : Two-player tic-tac-toe match sequencer with edge-detected inputs.
//            Optional turn timeout enabled by defining TTT_TURN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned FIRST_PLAYER   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [8:0] sq_req,
    output logic [8:0] A,
    output logic [8:0] B,
    output logic       turn,
    output logic [2:0] state,
    output logic [7:0] win_line,
    output logic       move_ack,
    output logic       move_err,
    output logic       game_over
`ifdef TTT_TURN_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    localparam logic FIRST_TURN = (FIRST_PLAYER != 0) ? PLAYER_B : PLAYER_A;

    state_t     state_q, state_d;
    logic [8:0] a_q, a_d, b_q, b_d;
    logic [8:0] sq_req_q;
    logic       start_q;
    logic       turn_q, turn_d;
    logic [7:0] win_q, win_d;
    logic       ack_q, ack_d, err_q, err_d;

    logic [8:0] new_sq;
    logic       start_rise;
    logic [8:0] mover_board;
    logic [7:0] mover_hits;

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    assign new_sq     = sq_req & ~sq_req_q;
    assign start_rise = start & ~start_q;

    // Only the player who just moved can have completed a line.
    assign mover_board = (turn_q == PLAYER_B) ? b_q : a_q;

    ttt_line_check u_line_check (
        .board_i    (mover_board),
        .line_hit_o (mover_hits)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            a_q      <= 9'd0;
            b_q      <= 9'd0;
            sq_req_q <= 9'd0;
            start_q  <= 1'b0;
            turn_q   <= FIRST_TURN;
            win_q    <= 8'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sq_req_q <= sq_req;
            start_q  <= start;
            turn_q   <= turn_d;
            win_q    <= win_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
`ifdef TTT_TURN_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        turn_d  = turn_q;
        win_d   = win_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        if (start_rise) begin
            state_d = PLAY;
            a_d     = 9'd0;
            b_d     = 9'd0;
            win_d   = 8'd0;
            turn_d  = FIRST_TURN;
        end else begin
            case (state_q)
                IDLE: ;
                PLAY: begin
                    if (new_sq != 9'd0) begin
                        if (is_onehot9(new_sq) && ((new_sq & (a_q | b_q)) == 9'd0)) begin
                            if (turn_q == PLAYER_B) b_d = b_q | new_sq;
                            else                    a_d = a_q | new_sq;
                            ack_d   = 1'b1;
                            state_d = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (mover_hits != 8'd0) begin
                        state_d = (turn_q == PLAYER_B) ? WIN_B : WIN_A;
                        win_d   = mover_hits;
                    end else if ((a_q | b_q) == FULL_BOARD) begin
                        state_d = DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                WIN_A, WIN_B, DRAW: begin
                    if (new_sq != 9'd0) err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef TTT_TURN_TIMEOUT_EN
        // Counter restarts on any accepted move or on leaving/re-entering PLAY.
        to_d  = 1'b0;
        cnt_d = '0;
        if (!start_rise && (state_q == PLAY) && !ack_d) begin
            if (cnt_q == CNT_MAX) begin
                to_d   = 1'b1;
                err_d  = 1'b1;
                turn_d = ~turn_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        A         = a_q;
        B         = b_q;
        turn      = turn_q;
        state     = state_q;
        win_line  = win_q;
        move_ack  = ack_q;
        move_err  = err_q;
        game_over = (state_q == WIN_A) || (state_q == WIN_B) || (state_q == DRAW);
`ifdef TTT_TURN_TIMEOUT_EN
        timeout   = to_q;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
// ============================================================================
// Module   : tb_ttt_game_ctrl
// Purpose  : Directed and randomized check of ttt_game_ctrl against a board
//            model; covers TTT_TURN_TIMEOUT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_game_ctrl;

    localparam int FIRST = 0;
    localparam int TO    = 16;

    localparam int LINE_SQ [0:7][0:2] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    logic       clk    = 1'b0;
    logic       res    = 1'b1;
    logic       start  = 1'b0;
    logic [8:0] sq_req = 9'd0;
    logic [8:0] A, B;
    logic       turn;
    logic [2:0] state;
    logic [7:0] win_line;
    logic       move_ack, move_err, game_over;
`ifdef TTT_TURN_TIMEOUT_EN
    logic       timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl #(
        .FIRST_PLAYER   (FIRST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .sq_req    (sq_req),
        .A         (A),
        .B         (B),
        .turn      (turn),
        .state     (state),
        .win_line  (win_line),
        .move_ack  (move_ack),
        .move_err  (move_err),
        .game_over (game_over)
`ifdef TTT_TURN_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Board model: cell value 0 = empty, 1 = player A, 2 = player B.
    int         cells [0:8];
    int         m_phase;
    int         m_turn;
    int         m_cnt;
    logic [7:0] m_win;
    bit         m_ack, m_err, m_to;
    logic [8:0] m_prev_sq;
    bit         m_prev_st;

    function automatic logic [8:0] owner_mask(input int who);
        logic [8:0] m;
        m = 9'd0;
        for (int i = 0; i < 9; i++) if (cells[i] == who) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_step();
        logic [8:0] nw;
        logic [7:0] lines;
        bit         sr;
        int         nbits, idx, empty;
        nw = sq_req & ~m_prev_sq;
        sr = start && !m_prev_st;
        m_prev_sq = sq_req;
        m_prev_st = start;
        m_ack = 0; m_err = 0; m_to = 0;
        if (sr) begin
            for (int i = 0; i < 9; i++) cells[i] = 0;
            m_win = 8'd0; m_turn = FIRST; m_phase = 1; m_cnt = 0;
        end else begin
            case (m_phase)
                1: begin
                    if (nw != 9'd0) begin
                        nbits = 0; idx = 0;
                        for (int i = 0; i < 9; i++) if (nw[i]) begin nbits++; idx = i; end
                        if (nbits == 1 && cells[idx] == 0) begin
                            cells[idx] = m_turn + 1; m_ack = 1; m_phase = 2; m_cnt = 0;
                        end else m_err = 1;
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    if (!m_ack) begin
                        if (m_cnt == TO - 1) begin
                            m_turn = 1 - m_turn; m_err = 1; m_to = 1; m_cnt = 0;
                        end else m_cnt++;
                    end
`endif
                end
                2: begin
                    lines = 8'd0;
                    for (int l = 0; l < 8; l++)
                        if (cells[LINE_SQ[l][0]] == m_turn + 1 && cells[LINE_SQ[l][1]] == m_turn + 1 &&
                            cells[LINE_SQ[l][2]] == m_turn + 1) lines[l] = 1'b1;
                    empty = 0;
                    for (int i = 0; i < 9; i++) if (cells[i] == 0) empty++;
                    m_cnt = 0;
                    if (lines != 8'd0) begin
                        m_win = lines; m_phase = (m_turn == 1) ? 4 : 3;
                    end else if (empty == 0) m_phase = 5;
                    else begin m_turn = 1 - m_turn; m_phase = 1; end
                end
                3, 4, 5: if (nw != 9'd0) m_err = 1;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 9; i++) cells[i] = 0;
            m_phase = 0; m_turn = FIRST; m_cnt = 0; m_win = 8'd0;
            m_ack = 0; m_err = 0; m_to = 0; m_prev_sq = 9'd0; m_prev_st = 0;
        end else begin
            model_step();
        end
    end

    always @(posedge clk) begin
        #1;
        check("state", 32'(state), 32'(m_phase));
        check("A", 32'(A), 32'(owner_mask(1)));
        check("B", 32'(B), 32'(owner_mask(2)));
        check("turn", 32'(turn), 32'(m_turn));
        check("win_line", 32'(win_line), 32'(m_win));
        check("move_ack", 32'(move_ack), 32'(m_ack));
        check("move_err", 32'(move_err), 32'(m_err));
        check("game_over", 32'(game_over), 32'(m_phase >= 3));
`ifdef TTT_TURN_TIMEOUT_EN
        check("timeout", 32'(timeout), 32'(m_to));
`endif
    end

    task automatic hit(input logic [8:0] m);
        sq_req = m;
        @(negedge clk);
    endtask

    task automatic rel();
        sq_req = 9'd0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic play_seq(input int n, input int sq [0:8]);
        for (int i = 0; i < n; i++) begin
            hit(9'(1 << sq[i]));
            rel();
        end
    endtask

    initial begin
        int seq [0:8];
        int r;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_B", 32'(B), 32'd0);
        check("rst_turn", 32'(turn), 32'(FIRST));
        check("rst_over", 32'(game_over), 32'd0);
        res = 1'b0;
        @(negedge clk);

        pulse_start();
        check("start_play", 32'(state), 32'd1);
        hit(9'h010);
        check("a4_ack", 32'(move_ack), 32'd1);
        check("a4_A", 32'(A), 32'h010);
        rel();
        check("a4_state", 32'(state), 32'd1);
        check("a4_turn", 32'(turn), 32'd1);
        hit(9'h010);
        check("occ_err", 32'(move_err), 32'd1);
        check("occ_B", 32'(B), 32'd0);
        check("occ_turn", 32'(turn), 32'd1);
        rel();
        hit(9'h003);
        check("multi_err", 32'(move_err), 32'd1);
        check("multi_A", 32'(A), 32'h010);
        check("multi_B", 32'(B), 32'd0);
        rel();

        pulse_start();
        seq = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
        play_seq(5, seq);
        check("win_state", 32'(state), 32'd3);
        check("win_line", 32'(win_line), 32'h01);
        check("win_over", 32'(game_over), 32'd1);
        hit(9'h020);
        check("frozen_err", 32'(move_err), 32'd1);
        check("frozen_B", 32'(B), 32'h018);
        rel();

        pulse_start();
        seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        play_seq(9, seq);
        check("draw_state", 32'(state), 32'd5);
        check("draw_full", 32'(A | B), 32'h1FF);
        check("draw_line", 32'(win_line), 32'd0);

        pulse_start();
        seq = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        play_seq(2, seq);
        pulse_start();
        check("abort_state", 32'(state), 32'd1);
        check("abort_board", 32'(A | B), 32'd0);
        check("abort_turn", 32'(turn), 32'(FIRST));
        start = 1'b1;
        sq_req = 9'h004;
        @(negedge clk);
        check("prio_ack", 32'(move_ack), 32'd0);
        check("prio_A", 32'(A), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("held_A", 32'(A), 32'd0);
        rel();

        hit(9'h001);
        rel();
        res = 1'b1;
        @(negedge clk);
        check("res_state", 32'(state), 32'd0);
        check("res_A", 32'(A), 32'd0);
        res = 1'b0;
        @(negedge clk);

`ifdef TTT_TURN_TIMEOUT_EN
        begin
            bit seen;
            seen = 0;
            pulse_start();
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (timeout) seen = 1;
            end
            check("to_seen", 32'(seen), 32'd1);
            check("to_turn", 32'(turn), 32'(1 - FIRST));
        end
`endif

        pulse_start();
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                res = 1'b1;
                @(negedge clk);
                res = 1'b0;
                @(negedge clk);
            end else if (r < 7) begin
                start = 1'b1;
                if ($urandom_range(0, 1) == 1) sq_req = 9'(1 << $urandom_range(0, 8));
                @(negedge clk);
                start = 1'b0;
                rel();
            end else if (r < 15) begin
                hit(9'($urandom));
                rel();
            end else if (r < 25) begin
                @(negedge clk);
            end else begin
                hit(9'(1 << $urandom_range(0, 8)));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                rel();
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Clocked game controller that sequences a two-player tic-tac-toe match over a 9-square board.
- Edge-detects square requests and alternates turns. Rejects occupied squares and multi-press requests.
- Holds both players' boards, detects win or draw, and freezes input after game end until restart.
- Sits between the square push-buttons and the board display/result logic. Replaces the latch-based input memory with a synchronous design.

Parameters:
- FIRST_PLAYER, 0, player that moves first after start (0 = A, 1 = B).
- TIMEOUT_CYCLES, 1000000, idle cycles before a turn is forfeited (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- res, input, 1, asynchronous active-high reset.
- start, input, 1, level; rising edge starts or restarts a game from any state.
- sq_req, input, 9, square buttons, level; bit i = square i, row-major from top-left.
- A, output, 9, player A occupied squares.
- B, output, 9, player B occupied squares.
- turn, output, 1, player to move (0 = A, 1 = B).
- state, output, 3, FSM state encoding from the package.
- win_line, output, 8, one-hot winning line(s): rows 0-2, columns 3-5, diagonal 6 (0,4,8), anti-diagonal 7 (2,4,6).
- move_ack, output, 1, one-cycle pulse when a move is accepted.
- move_err, output, 1, one-cycle pulse when a move is rejected.
- game_over, output, 1, high in WIN_A, WIN_B and DRAW.

Behaviour:
- Reset (async, res = 1):
  - A = B = 0, turn = FIRST_PLAYER, state = IDLE.
  - win_line = 0, move_ack = move_err = 0, game_over = 0.
  - Edge-detect registers cleared.
- Edge detection: new = sq_req & ~sq_req_q and start_rise = start & ~start_q, both registered every cycle in all states.
- States: IDLE, PLAY, CHECK, WIN_A, WIN_B, DRAW.
- IDLE: start_rise -> PLAY; A and B cleared, turn = FIRST_PLAYER.
- PLAY, when new is nonzero:
  - Exactly one bit set and the square is free in (A | B): set the bit in A (turn = 0) or B (turn = 1) at the next edge; pulse move_ack; go to CHECK.
  - More than one bit set, or the square is occupied: pulse move_err; board and turn unchanged; stay in PLAY.
- CHECK (one cycle), evaluated on the updated board:
  - Mover completes any line -> WIN_A or WIN_B; win_line = all completed lines of the mover.
  - Otherwise (A | B) == 9'h1FF -> DRAW.
  - Otherwise turn toggles -> PLAY.
- Latency: button edge at cycle t -> move_ack and board update visible at t+1 -> result state at t+2.
- WIN_A / WIN_B / DRAW: A, B, win_line and turn held. Any new square edge pulses move_err. Only start_rise leaves the state: clear board and win_line -> PLAY.
- start_rise in PLAY or CHECK: abort the game, clear everything -> PLAY. start takes priority over a same-cycle move.
- A button held across start still produces no new edge, so it is not accepted.
- res mid-game returns to IDLE immediately, asynchronously.
- win_line may hold two bits, e.g. a double line completed by one move.

Optional Feature:
- Macro: TTT_TURN_TIMEOUT_EN.
- Enabled:
  - Counter of TIMEOUT_CYCLES width runs in PLAY and clears on any accepted move or state change.
  - On reaching TIMEOUT_CYCLES-1: turn toggles, move_err pulses, counter restarts.
  - An output port timeout (1 bit) pulses in the same cycle.
- Disabled: no counter, no timeout port. A turn waits indefinitely.

Decomposition:
- Package ttt_pkg holds:
  - state_t enum: IDLE = 0, PLAY = 1, CHECK = 2, WIN_A = 3, WIN_B = 4, DRAW = 5.
  - LINES constant: 8 x 9-bit line masks.
  - Constant FULL_BOARD = 9'h1FF.
  - Player encoding: PLAYER_A = 0, PLAYER_B = 1.
- One sub-module ttt_line_check: combinational, board (9 bits) in, line_hit (8 bits) out. Instantiated once on the mover's updated board.

Test Plan:
- Reset, start, A presses sq 4 -> move_ack at t+1, A = 9'h010, turn = 1 in PLAY at t+2.
- B presses sq 4 (occupied) -> move_err pulse; B = 0 and turn = 1 unchanged.
- B presses sq 0 and sq 1 in the same cycle -> move_err; no board change.
- A takes 0, 1, 2 (B takes 3, 4) -> state WIN_A, win_line = 8'h01, game_over = 1; further presses give only move_err.
- Full board with no line: sequence 0A,1B,2A,4B,3A,5B,7A,6B,8A -> DRAW, A|B = 9'h1FF, win_line = 0.
- Mid-game start edge, and separately res -> board cleared. start gives PLAY with turn = FIRST_PLAYER; res gives IDLE. With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 16, an idle turn -> timeout pulse after 16 cycles and turn flips.
